nist_runs_test: RTL and testbench

NIST_RUNS_TEST -- requirements
Module: nist_runs_test

---
 rtl/nist_runs_test.sv | 162 ++++++++++++++++
 tb/tb_nist_runs_test.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/nist_runs_test.sv
// nist_runs_test
// --------------
// Streaming NIST SP800-22 style runs test over a block of BLOCK_LEN bits.
// A start pulse opens a block. Bits are then accepted one per valid cycle,
// and the block counts the ones and the runs (maximal stretches of equal
// bits). One cycle after the last bit, the block evaluates both counts
// against their pass windows. The result is then held in DONE until the
// next start or reset.
//
// Handshake: a bit is transferred on every rising edge where
// bit_valid && bit_ready. bit_ready is high only while collecting and does
// not depend on bit_valid. Gaps in bit_valid simply stall the block.
//
// Ports
//   clk          clock; all state changes on its rising edge
//   rst          synchronous active-high reset
//   start        one-cycle pulse that opens a block (honoured in IDLE/DONE)
//   bit_in       sample bit from the entropy source
//   bit_valid    bit_in is valid this cycle
//   bit_ready    block accepts a bit this cycle (COLLECT only)
//   busy         high in COLLECT and EVAL
//   ones_count   ones accepted in the current or last block
//   runs_count   runs in the current or last block
//   result_valid result outputs are stable and meaningful (DONE)
//   freq_pass    ONES_LO <= ones_count <= ONES_HI
//   runs_pass    RUNS_LO <= runs_count <= RUNS_HI, and freq_pass
//   dbg_state    current FSM state, for observation only
module nist_runs_test #(
    parameter int BLOCK_LEN = 128,
    parameter int ONES_LO   = 53,
    parameter int ONES_HI   = 75,
    parameter int RUNS_LO   = 53,
    parameter int RUNS_HI   = 76,
    localparam int CW       = $clog2(BLOCK_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_in,
    input  logic          bit_valid,
    output logic          bit_ready,
    output logic          busy,
    output logic [CW-1:0] ones_count,
    output logic [CW-1:0] runs_count,
    output logic          result_valid,
    output logic          freq_pass,
    output logic          runs_pass,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EVAL    = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_IDX  = CW'(BLOCK_LEN - 1);
    localparam logic [CW-1:0] ONES_LO_C = CW'(ONES_LO);
    localparam logic [CW-1:0] ONES_HI_C = CW'(ONES_HI);
    localparam logic [CW-1:0] RUNS_LO_C = CW'(RUNS_LO);
    localparam logic [CW-1:0] RUNS_HI_C = CW'(RUNS_HI);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] ones_q, ones_d;
    logic [CW-1:0] runs_q, runs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;
    logic          rv_q, rv_d;
    logic          fp_q, fp_d;
    logic          rp_q, rp_d;
    logic          accept;
    logic          freq_ok;

    assign accept  = bit_valid && (state_q == COLLECT);
    assign freq_ok = (ones_q >= ONES_LO_C) && (ones_q <= ONES_HI_C);

    always_comb begin
        state_d = state_q;
        ones_d  = ones_q;
        runs_d  = runs_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        rv_d    = rv_q;
        fp_d    = fp_q;
        rp_d    = rp_q;
        case (state_q)
            IDLE, DONE: begin
                // A bit presented together with start is never taken:
                // bit_ready is low here, so the first accept is in COLLECT.
                if (start) begin
                    state_d = COLLECT;
                    ones_d  = '0;
                    runs_d  = '0;
                    cnt_d   = '0;
                    prev_d  = 1'b0;
                    rv_d    = 1'b0;
                    fp_d    = 1'b0;
                    rp_d    = 1'b0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    ones_d = ones_q + CW'(bit_in);
                    // The first bit of a block always opens a run; later
                    // bits open a new run only when they differ.
                    if (cnt_q == '0) begin
                        runs_d = ONE_C;
                    end else if (bit_in != prev_q) begin
                        runs_d = runs_q + ONE_C;
                    end
                    prev_d = bit_in;
                    cnt_d  = cnt_q + ONE_C;
                    if (cnt_q == LAST_IDX) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                fp_d    = freq_ok;
                // The runs test is meaningless when the frequency test fails.
                rp_d    = freq_ok && (runs_q >= RUNS_LO_C) && (runs_q <= RUNS_HI_C);
                rv_d    = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ones_q  <= '0;
            runs_q  <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            rv_q    <= 1'b0;
            fp_q    <= 1'b0;
            rp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            runs_q  <= runs_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            rv_q    <= rv_d;
            fp_q    <= fp_d;
            rp_q    <= rp_d;
        end
    end

    assign bit_ready    = (state_q == COLLECT);
    assign busy         = (state_q == COLLECT) || (state_q == EVAL);
    assign ones_count   = ones_q;
    assign runs_count   = runs_q;
    assign result_valid = rv_q;
    assign freq_pass    = fp_q;
    assign runs_pass    = rp_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_nist_runs_test.sv
// Testbench for nist_runs_test with BLOCK_LEN=16, ones window 6..10 and
// runs window 5..12. Blocks are described as 16-bit vectors sent MSB first.
// Expected counts and pass flags come from a reference model that works
// directly on the bit vector.
module tb_nist_runs_test;

    localparam int BL = 16;
    localparam int CW = $clog2(BL + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EVAL    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic          busy;
    logic [CW-1:0] ones_count;
    logic [CW-1:0] runs_count;
    logic          result_valid;
    logic          freq_pass;
    logic          runs_pass;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    nist_runs_test #(
        .BLOCK_LEN(BL), .ONES_LO(6), .ONES_HI(10), .RUNS_LO(5), .RUNS_HI(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .busy(busy),
        .ones_count(ones_count), .runs_count(runs_count),
        .result_valid(result_valid), .freq_pass(freq_pass),
        .runs_pass(runs_pass), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: ones = popcount of the first n bits, runs = 1 plus
    // the number of neighbouring pairs that differ (0 for an empty prefix).
    function automatic void model(input logic [15:0] p, input int n,
                                  output int ones, output int runs);
        logic b [$];
        ones = 0;
        runs = 0;
        for (int i = 0; i < n; i++) b.push_back(p[15-i]);
        foreach (b[i]) ones += int'(b[i]);
        if (n > 0) begin
            runs = 1;
            for (int i = 1; i < n; i++) if (b[i] != b[i-1]) runs++;
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
        check({tag, "_ready"}, 32'(bit_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ones"}, 32'(ones_count), 0);
        check({tag, "_runs"}, 32'(runs_count), 0);
        check({tag, "_rv"}, 32'(result_valid), 0);
        check({tag, "_fp"}, 32'(freq_pass), 0);
        check({tag, "_rp"}, 32'(runs_pass), 0);
    endtask

    // gap_mode: 0 = valid every cycle, 1 = idle cycle between bits,
    // 2 = random idle cycles. start_noise pulses start randomly mid-block.
    // start_with_valid presents a bit together with the opening start.
    task automatic run_block(input string tag, input logic [15:0] pat,
                             input int gap_mode, input bit start_noise,
                             input bit start_with_valid);
        int eo, er;
        bit gap;
        start     = 1'b1;
        bit_valid = start_with_valid;
        bit_in    = 1'b1;
        tick();
        start     = 1'b0;
        bit_valid = 1'b0;
        check({tag, "_open_state"}, 32'(dbg_state), 32'(S_COLLECT));
        check({tag, "_open_ones"}, 32'(ones_count), 0);
        check({tag, "_open_runs"}, 32'(runs_count), 0);
        check({tag, "_open_rv"}, 32'(result_valid), 0);
        check({tag, "_open_busy"}, 32'(busy), 1);
        for (int i = 0; i < BL; i++) begin
            gap = (gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
            if (gap) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
                start     = start_noise ? ($urandom_range(0, 2) == 0) : 1'b0;
                tick();
                model(pat, i, eo, er);
                check({tag, "_gap_ones"}, 32'(ones_count), 32'(eo));
                check({tag, "_gap_runs"}, 32'(runs_count), 32'(er));
                check({tag, "_gap_state"}, 32'(dbg_state), 32'(S_COLLECT));
            end
            bit_valid = 1'b1;
            bit_in    = pat[15-i];
            start     = start_noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            tick();
        end
        bit_valid = 1'b0;
        start     = 1'b0;
        model(pat, BL, eo, er);
        check({tag, "_eval_state"}, 32'(dbg_state), 32'(S_EVAL));
        check({tag, "_eval_ready"}, 32'(bit_ready), 0);
        check({tag, "_eval_rv"}, 32'(result_valid), 0);
        check({tag, "_eval_busy"}, 32'(busy), 1);
        tick();
        check({tag, "_done_state"}, 32'(dbg_state), 32'(S_DONE));
        check({tag, "_rv"}, 32'(result_valid), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_ones"}, 32'(ones_count), 32'(eo));
        check({tag, "_runs"}, 32'(runs_count), 32'(er));
        check({tag, "_fp"}, 32'(freq_pass), 32'(eo >= 6 && eo <= 10));
        check({tag, "_rp"}, 32'(runs_pass), 32'(eo >= 6 && eo <= 10 && er >= 5 && er <= 12));
        // Results must hold in DONE while stray bits arrive.
        for (int k = 0; k < 2; k++) begin
            bit_valid = 1'($urandom);
            bit_in    = 1'($urandom);
            tick();
            check({tag, "_hold_ones"}, 32'(ones_count), 32'(eo));
            check({tag, "_hold_runs"}, 32'(runs_count), 32'(er));
            check({tag, "_hold_rv"}, 32'(result_valid), 1);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Stray bits in IDLE change nothing.
        for (int k = 0; k < 4; k++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            tick();
        end
        bit_valid = 1'b0;
        check_all_zero("idle_bits");

        run_block("alt", 16'h5555, 0, 1'b0, 1'b0);
        run_block("p0011", 16'h3333, 1, 1'b0, 1'b0);
        run_block("ones", 16'hFFFF, 0, 1'b0, 1'b0);
        // Opening start from DONE with a bit presented: bit not counted.
        run_block("donestart", 16'h0F0F, 0, 1'b0, 1'b1);
        run_block("noise", 16'h6996, 0, 1'b1, 1'b0);

        // Reset after 9 accepts discards the block.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            tick();
        end
        rst       = 1'b1;
        start     = 1'b1;
        bit_valid = 1'b1;
        tick();
        check_all_zero("midrst");
        rst       = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        tick();
        check_all_zero("postrst");
        run_block("after_rst", 16'h3333, 0, 1'b0, 1'b0);

        for (int r = 0; r < 20; r++) begin
            run_block("rand", 16'($urandom), 2, 1'b1, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
